irq_ctrl: RTL and testbench

Machine-mode interrupt controller that sits between the core's external interrupt pins and the CSR register file. It edge-detects and latches up to NIRQ interrupt sources and arbitrates among them. It presents exactly one granted request on the CSR file's `interrupt_i` at an instruction boundary, then holds off further interrupts until the handler executes MRET. Nesting is not supported.

---
 rtl/irq_ctrl_pkg.sv | 22 ++
 rtl/irq_arbiter.sv | 56 +++++
 rtl/irq_ctrl.sv | 134 +++++++++++++
 tb/tb_irq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the machine-mode interrupt controller.
package irq_ctrl_pkg;

    // Controller FSM encoding.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } irq_state_e;

    // Upper bound on the number of interrupt sources.
    localparam int unsigned IrqNirqMax = 8;

    // mcause code for a machine external interrupt.
    localparam logic [4:0] IrqMcauseExt = 5'd11;

    // Isolate the lowest set bit of a request vector (two's complement trick).
    function automatic logic [IrqNirqMax-1:0] lowest_one(input logic [IrqNirqMax-1:0] v);
        return v & (~v + {{(IrqNirqMax-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational arbiter over latched interrupt requests.
// Fixed priority (lowest index wins) by default; round-robin starting at ptr
// when IRQ_ARB_RR_EN is defined.
module irq_arbiter
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NIRQ = 2,
    parameter int unsigned IDW  = 3
) (
    input  logic [NIRQ-1:0] pending,
    input  logic [IDW-1:0]  ptr,
    output logic [NIRQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    logic [IrqNirqMax-1:0] req_ext;
    logic [IrqNirqMax-1:0] sel;

    assign req_ext = IrqNirqMax'(pending);

`ifdef IRQ_ARB_RR_EN
    logic [IrqNirqMax-1:0] hi_mask;
    logic [IrqNirqMax-1:0] req_hi;

    // Prefer requests at or above the pointer; wrap to the bottom otherwise.
    always_comb begin
        hi_mask = ~((IrqNirqMax'(1) << ptr) - IrqNirqMax'(1));
        req_hi  = req_ext & hi_mask;
        if (|req_hi) begin
            sel = lowest_one(req_hi);
        end else begin
            sel = lowest_one(req_ext);
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Fixed priority: lowest index wins.
    always_comb begin
        sel = lowest_one(req_ext);
    end
`endif

    // Encode the selected one-hot into grant vector and index.
    always_comb begin
        grant_id = '0;
        for (int i = 0; i < IrqNirqMax; i++) begin
            if (sel[i]) begin
                grant_id = IDW'(i);
            end
        end
        grant = sel[NIRQ-1:0];
    end

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: edge-detects and latches NIRQ sources,
// presents one granted request to the CSR file at an instruction boundary and
// blocks further interrupts until MRET. No nesting.
// Define IRQ_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NIRQ = 2,
    parameter int unsigned IDW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq_i,
    input  logic            mie_bit,
    input  logic            stop_fetch,
    input  logic            jump,
    input  logic            mret_i,
    output logic [NIRQ-1:0] interrupt_o,
    output logic [IDW-1:0]  irq_id_o,
    output logic            irq_active_o,
    output logic [NIRQ-1:0] pending_o
);

    irq_state_e      state_q, state_d;
    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [NIRQ-1:0] irq_edge;
    logic [NIRQ-1:0] grant_oh;
    logic [NIRQ-1:0] clr;
    logic            take;
    logic [IDW-1:0]  arb_ptr;
    logic [NIRQ-1:0] arb_grant;
    logic [IDW-1:0]  arb_id;
    logic            unused_arb_grant;

    assign irq_edge         = irq_i & ~irq_q;
    assign grant_oh         = NIRQ'(1) << grant_q;
    assign unused_arb_grant = ^arb_grant;

    irq_arbiter #(
        .NIRQ (NIRQ),
        .IDW  (IDW)
    ) u_arbiter (
        .pending  (pending_q),
        .ptr      (arb_ptr),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

`ifdef IRQ_ARB_RR_EN
    logic [IDW-1:0] ptr_q, ptr_d;

    // Advance the round-robin pointer past the source just taken.
    always_comb begin
        ptr_d = ptr_q;
        if (take) begin
            ptr_d = (grant_q == IDW'(NIRQ - 1)) ? '0 : grant_q + IDW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign arb_ptr = ptr_q;
`else
    assign arb_ptr = '0;
`endif

    // Next state: request on pending+MIE, take at a clean boundary, release on MRET.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        take    = 1'b0;
        case (state_q)
            StIdle: begin
                if (|pending_q && mie_bit) begin
                    state_d = StReq;
                    grant_d = arb_id;
                end
            end
            StReq: begin
                if (!mie_bit) begin
                    state_d = StIdle;
                end else if (!stop_fetch && !jump) begin
                    take    = 1'b1;
                    state_d = StService;
                end
            end
            StService: begin
                if (mret_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pending latch: a same-cycle edge beats the clear of the taken source.
    always_comb begin
        clr       = take ? grant_oh : '0;
        pending_d = (pending_q & ~clr) | irq_edge;
    end

    // State, edge history, pending and grant registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            irq_q     <= '0;
            pending_q <= '0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_i;
            pending_q <= pending_d;
            grant_q   <= grant_d;
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        interrupt_o  = (state_q == StReq) ? grant_oh : '0;
        irq_id_o     = (state_q == StIdle) ? '0 : grant_q;
        irq_active_o = (state_q == StService);
        pending_o    = pending_q;
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios push expected
// request/service records; a monitor pops and compares on each presentation.
module tb_irq_ctrl;

    localparam int unsigned NIRQ = 2;
    localparam int unsigned IDW  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NIRQ-1:0] irq_i = '0;
    logic            mie_bit = 1'b0;
    logic            stop_fetch = 1'b0;
    logic            jump = 1'b0;
    logic            mret_i = 1'b0;
    logic [NIRQ-1:0] interrupt_o;
    logic [IDW-1:0]  irq_id_o;
    logic            irq_active_o;
    logic [NIRQ-1:0] pending_o;

    typedef struct {
        logic [NIRQ-1:0] irq;
        logic [IDW-1:0]  id;
        logic            act;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [NIRQ-1:0] prev_int = '0;
    logic            prev_act = 1'b0;

`ifdef IRQ_ARB_RR_EN
    localparam logic [NIRQ-1:0] BothFirstOh  = 2'b10;
    localparam logic [IDW-1:0]  BothFirstId  = 3'd1;
    localparam logic [NIRQ-1:0] BothSecondOh = 2'b01;
    localparam logic [IDW-1:0]  BothSecondId = 3'd0;
`else
    localparam logic [NIRQ-1:0] BothFirstOh  = 2'b01;
    localparam logic [IDW-1:0]  BothFirstId  = 3'd0;
    localparam logic [NIRQ-1:0] BothSecondOh = 2'b10;
    localparam logic [IDW-1:0]  BothSecondId = 3'd1;
`endif

    irq_ctrl #(
        .NIRQ (NIRQ),
        .IDW  (IDW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_i        (irq_i),
        .mie_bit      (mie_bit),
        .stop_fetch   (stop_fetch),
        .jump         (jump),
        .mret_i       (mret_i),
        .interrupt_o  (interrupt_o),
        .irq_id_o     (irq_id_o),
        .irq_active_o (irq_active_o),
        .pending_o    (pending_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NIRQ-1:0] oh, input logic [IDW-1:0] id, input logic act);
        exp_t e;
        e.irq = oh;
        e.id  = id;
        e.act = act;
        sb_q.push_back(e);
    endtask

    // Request presented to CSR file and its following service entry.
    task automatic push_trap(input logic [NIRQ-1:0] oh, input logic [IDW-1:0] id);
        push(oh, id, 1'b0);
        push('0, id, 1'b1);
    endtask

    task automatic do_mret();
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
    endtask

    // Monitor: compare on each rising presentation of a request or service.
    always @(negedge clk) begin
        if (rst && ((interrupt_o != '0 && prev_int == '0) || (irq_active_o && !prev_act))) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got int=%b id=%0d act=%b, expected nothing",
                         interrupt_o, irq_id_o, irq_active_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_interrupt", 32'(interrupt_o), 32'(e.irq));
                chk("sb_id", 32'(irq_id_o), 32'(e.id));
                chk("sb_active", 32'(irq_active_o), 32'(e.act));
            end
        end
        prev_int <= interrupt_o;
        prev_act <= irq_active_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_interrupt", 32'(interrupt_o), 32'h0);
        chk("rst_id", 32'(irq_id_o), 32'h0);
        chk("rst_active", 32'(irq_active_o), 32'h0);
        chk("rst_pending", 32'(pending_o), 32'h0);
        rst = 1'b1;
        mie_bit = 1'b1;
        repeat (2) step();

        // Single source 0: 2-cycle latency to trap
        irq_i = 2'b01;
        push_trap(2'b01, 3'd0);
        step();
        chk("s1_pending", 32'(pending_o), 32'h1);
        chk("s1_no_early_int", 32'(interrupt_o), 32'h0);
        irq_i = 2'b00;
        step();
        chk("s1_interrupt", 32'(interrupt_o), 32'h1);
        step();
        chk("s1_active", 32'(irq_active_o), 32'h1);
        chk("s1_id", 32'(irq_id_o), 32'h0);
        chk("s1_pending_clr", 32'(pending_o), 32'h0);
        do_mret();
        chk("s1_mret_idle", 32'(irq_active_o), 32'h0);

        // Simultaneous edges on both sources
        irq_i = 2'b11;
        push_trap(BothFirstOh, BothFirstId);
        push_trap(BothSecondOh, BothSecondId);
        step();
        chk("s2_pending", 32'(pending_o), 32'h3);
        irq_i = 2'b00;
        step();
        chk("s2_first", 32'(interrupt_o), 32'(BothFirstOh));
        step();
        chk("s2_pending_left", 32'(pending_o), 32'(BothSecondOh));
        do_mret();
        chk("s2_mret_idle", 32'(irq_active_o), 32'h0);
        step();
        chk("s2_second", 32'(interrupt_o), 32'(BothSecondOh));
        step();
        chk("s2_pending_empty", 32'(pending_o), 32'h0);
        do_mret();

        // jump blocks the take for 3 REQ cycles
        jump = 1'b1;
        irq_i = 2'b10;
        push_trap(2'b10, 3'd1);
        step();
        irq_i = 2'b00;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("s3_held_int", 32'(interrupt_o), 32'h2);
            chk("s3_no_take", 32'(irq_active_o), 32'h0);
            step();
        end
        chk("s3_still_req", 32'(interrupt_o), 32'h2);
        jump = 1'b0;
        step();
        chk("s3_taken", 32'(irq_active_o), 32'h1);
        do_mret();

        // MIE clear: request latches but the FSM stays idle
        mie_bit = 1'b0;
        irq_i = 2'b10;
        step();
        irq_i = 2'b00;
        chk("s4_pending", 32'(pending_o), 32'h2);
        step();
        chk("s4_idle_int", 32'(interrupt_o), 32'h0);
        chk("s4_idle_pending", 32'(pending_o), 32'h2);
        step();
        chk("s4_idle_active", 32'(irq_active_o), 32'h0);
        mie_bit = 1'b1;
        push_trap(2'b10, 3'd1);
        step();
        chk("s4_req", 32'(interrupt_o), 32'h2);
        step();
        chk("s4_active", 32'(irq_active_o), 32'h1);
        do_mret();

        // Re-edge of the in-service source
        irq_i = 2'b01;
        push_trap(2'b01, 3'd0);
        push_trap(2'b01, 3'd0);
        step();
        irq_i = 2'b00;
        step();
        step();
        chk("s5_pending_clr", 32'(pending_o), 32'h0);
        irq_i = 2'b01;
        step();
        chk("s5_relatched", 32'(pending_o), 32'h1);
        chk("s5_in_service", 32'(irq_active_o), 32'h1);
        irq_i = 2'b00;
        do_mret();
        chk("s5_mret_int", 32'(interrupt_o), 32'h0);
        step();
        chk("s5_rereq", 32'(interrupt_o), 32'h1);
        chk("s5_rereq_id", 32'(irq_id_o), 32'h0);
        step();
        chk("s5_pending_done", 32'(pending_o), 32'h0);
        do_mret();

        // Asynchronous reset while in service with both pending
        irq_i = 2'b01;
        push_trap(2'b01, 3'd0);
        step();
        irq_i = 2'b00;
        step();
        step();
        irq_i = 2'b11;
        step();
        chk("s6_pending", 32'(pending_o), 32'h3);
        chk("s6_active", 32'(irq_active_o), 32'h1);
        #3;
        rst = 1'b0;
        #1;
        chk("s6_rst_int", 32'(interrupt_o), 32'h0);
        chk("s6_rst_id", 32'(irq_id_o), 32'h0);
        chk("s6_rst_active", 32'(irq_active_o), 32'h0);
        chk("s6_rst_pending", 32'(pending_o), 32'h0);
        irq_i = 2'b00;
        step();
        step();
        rst = 1'b1;
        repeat (3) step();
        chk("s6_post_pending", 32'(pending_o), 32'h0);
        chk("s6_post_int", 32'(interrupt_o), 32'h0);
        irq_i = 2'b10;
        push_trap(2'b10, 3'd1);
        step();
        irq_i = 2'b00;
        step();
        chk("s6_new_req", 32'(interrupt_o), 32'h2);
        step();
        do_mret();

        // Take source 0 alone, then both pending together
        irq_i = 2'b01;
        push_trap(2'b01, 3'd0);
        step();
        irq_i = 2'b00;
        step();
        step();
        do_mret();
        irq_i = 2'b11;
`ifdef IRQ_ARB_RR_EN
        push_trap(2'b10, 3'd1);
        push_trap(2'b01, 3'd0);
`else
        push_trap(2'b01, 3'd0);
        push_trap(2'b10, 3'd1);
`endif
        step();
        irq_i = 2'b00;
        step();
        step();
        do_mret();
        step();
        step();
        do_mret();
        repeat (3) step();

        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
